// File: rtl/pipe_mux_n_if.sv
// Handshake/data bundle for pipe_mux_n: upstream beat, downstream beat, flush,
// select-error and transfer-count observation.
interface pipe_mux_n_if #(
  parameter int N     = 6,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               flush;
  logic               sel_err;
  logic               sel_err_clr;
  logic [CNT_W-1:0]   xfer_cnt;

  modport master (
    output in_data, sel, in_valid, out_ready, flush, sel_err_clr,
    input  in_ready, out_data, out_valid, sel_err, xfer_cnt
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready, flush, sel_err_clr,
    output in_ready, out_data, out_valid, sel_err, xfer_cnt
  );
endinterface

// File: rtl/pipe_mux_n.sv
// Registered N:1 mux stage with valid/ready, flush, sticky out-of-range select
// flag and wrapping transfer counter. PIPE_MUX_SKID_EN adds a skid register.
module pipe_mux_n #(
  parameter int N     = 6,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  pipe_mux_n_if.slave  bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] w_ch [N];
  logic             w_oor;
  logic [SEL_W-1:0] w_sel_idx;
  logic [WIDTH-1:0] w_mux;
  logic             w_acc;
  logic             w_xfer;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_sel_err;
  logic [CNT_W-1:0] r_cnt;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign w_ch[k] = bus.in_data[k*WIDTH +: WIDTH];
  end

  // Out-of-range selects fall back to the last channel, like the legacy default arm.
  if ((1 << SEL_W) == N) begin : g_pow2
    assign w_oor = 1'b0;
  end else begin : g_npow2
    assign w_oor = bus.sel > SEL_W'(N-1);
  end

  assign w_sel_idx = w_oor ? SEL_W'(N-1) : bus.sel;
  assign w_mux     = w_ch[w_sel_idx];
  assign w_acc     = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_xfer    = r_out_valid && bus.out_ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      if (w_xfer)
        r_cnt <= r_cnt + 1'b1;
      if (w_acc && w_oor)
        r_sel_err <= 1'b1;
      else if (bus.sel_err_clr)
        r_sel_err <= 1'b0;
    end
  end

`ifdef PIPE_MUX_SKID_EN
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             r_in_ready;

  assign bus.in_ready = r_in_ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_out_valid || bus.out_ready) begin
      // Output slot frees up: the skid entry is older than any new beat.
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_acc) begin
        r_out_data  <= w_mux;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid_data  <= w_mux;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end
`else
  assign bus.in_ready = !r_out_valid || bus.out_ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_out_data  <= w_mux;
      r_out_valid <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.sel_err   = r_sel_err;
  assign bus.xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_pipe_mux_n.sv
// Scoreboard bench for pipe_mux_n (N=6, WIDTH=32, CNT_W=4); capacity model
// follows PIPE_MUX_SKID_EN.
module tb_pipe_mux_n;
  localparam int N = 6;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
`ifdef PIPE_MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_mux_n_if #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pipe_mux_n #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] ch [N];
  logic [WIDTH-1:0] q [$];
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_err = 1'b0;
  bit               use_rnd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_mux(input int s);
    return (s >= N) ? ch[N-1] : ch[s];
  endfunction

  task automatic load_ch();
    for (int k = 0; k < N; k++) begin
      ch[k] = use_rnd ? WIDTH'($urandom) : (32'h1000_0000 + WIDTH'(k));
      bus.in_data[k*WIDTH +: WIDTH] = ch[k];
    end
  endtask

  // One cycle: drive at negedge, check registered/comb outputs, advance model, clock.
  task automatic step(input bit iv, input int s, input bit ordy, input bit fl, input bit clr);
    bit rdy, acc, xf;
    @(negedge clk);
    bus.in_valid = iv; bus.sel = 3'(s); bus.out_ready = ordy;
    bus.flush = fl; bus.sel_err_clr = clr;
    load_ch();
    #1;
    chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
    chk("sel_err", 32'(bus.sel_err), 32'(m_err));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("out_data", bus.out_data, q[0]);
    rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    acc = iv && rdy && !fl;
    xf  = (q.size() > 0) && ordy;
    if (xf) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (fl) q.delete();
    else if (acc) q.push_back(model_mux(s));
    if (acc && s >= N) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.sel = '0; bus.out_ready = 1'b1;
    bus.flush = 1'b0; bus.sel_err_clr = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    q.delete(); m_cnt = '0; m_err = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.sel = '0; bus.out_ready = 1'b0;
    bus.flush = 1'b0; bus.sel_err_clr = 1'b0; bus.in_data = '0;
    load_ch();

    // Reset held two cycles with in_valid high
    do_reset(2);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);

    // Sweep all channels
    for (int k = 0; k < N; k++) step(1, k, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    #1;
    chk("sweep_cnt", 32'(bus.xfer_cnt), 32'd6);
    chk("sweep_err", 32'(bus.sel_err), 32'd0);

    // Out-of-range select, set-beats-clear, lone clear
    step(1, 7, 1, 0, 0);
    #1;
    chk("oor_data", bus.out_data, 32'h1000_0005);
    chk("oor_err", 32'(bus.sel_err), 32'd1);
    step(1, 6, 1, 0, 1);
    #1;
    chk("oor_set_wins", 32'(bus.sel_err), 32'd1);
    step(0, 0, 1, 0, 1);
    #1;
    chk("oor_clr", 32'(bus.sel_err), 32'd0);
    step(0, 0, 1, 0, 0);

    // Backpressure: 3 stalled cycles, then drain
    use_rnd = 1'b1;
    for (int i = 0; i < 3; i++) step(1, i, 0, 0, 0);
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), SKID ? 32'd0 : 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

    // Flush with beats buffered and a beat offered
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 3, 0, 1, 0);
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // Flush with a transfer in the same cycle
    step(1, 4, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // Mid-stream reset discards buffered data
    step(1, 2, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    do_reset(1);
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(bus.xfer_cnt), 32'd0);

    // Counter wrap: 17 transfers on a 4-bit counter
    use_rnd = 1'b0;
    for (int i = 0; i < 17; i++) step(1, i % N, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    #1;
    chk("wrap_cnt", 32'(bus.xfer_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
